irq_input_conditioner: RTL and testbench

Conditions four raw asynchronous interrupt request lines before they reach the interrupt controller's `irq_trigger_i` inputs. Per line, it synchronizes the input and applies a programmable glitch filter. It then produces either a level or a single-cycle edge trigger, and keeps a saturating event count. Configuration and counters are accessed over AMBA 3 APB on the same `pclk_i` domain as the controller.

---
 rtl/irq_input_conditioner_if.sv | 22 ++
 rtl/irq_input_conditioner.sv | 179 +++++++++++++++++
 tb/tb_irq_input_conditioner.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_input_conditioner_if.sv
// APB3 slave-side bus bundle for the interrupt input conditioner.
// Signal names carry the direction as seen from the conditioner.
interface irq_input_conditioner_if;
  logic        psel_i;
  logic        penable_i;
  logic        pwrite_i;
  logic [31:0] paddr_i;
  logic [31:0] pwdata_i;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/irq_input_conditioner.sv
// Four-line interrupt input conditioner: 2-flop synchronizer, glitch filter,
// level/edge trigger generation and saturating event counters behind APB3.
module irq_input_conditioner #(
  parameter int FILTER_W = 4,
  parameter int CNT_W    = 8
) (
  input  logic                   pclk_i,
  input  logic                   rst_i,
  irq_input_conditioner_if.slave apb,
  input  logic [3:0]             irq_i,
  output logic [3:0]             irq_trigger_o
);

  typedef enum logic [3:0] {
    REG_CTRL    = 4'd0,
    REG_MODE    = 4'd1,
    REG_FILTER  = 4'd2,
    REG_RAW     = 4'd3,
    REG_CNT0    = 4'd4,
    REG_CNT1    = 4'd5,
    REG_CNT2    = 4'd6,
    REG_CNT3    = 4'd7,
    REG_CNT_CLR = 4'd8
  } reg_idx_e;

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'b00,
    MODE_RISE  = 2'b01,
    MODE_FALL  = 2'b10,
    MODE_BOTH  = 2'b11
  } trig_mode_e;

  logic                          en_q, en_d;
  logic [7:0]                    mode_q, mode_d;
  logic [FILTER_W-1:0]           filt_n_q, filt_n_d;
  logic [3:0]                    s1_q, s1_d, s2_q, s2_d;
  logic [3:0]                    f_q, f_d, f_dly_q, f_dly_d;
  logic [3:0][FILTER_W-1:0]      fcnt_q, fcnt_d;
  logic [3:0]                    trig_q, trig_d;
  logic [3:0][CNT_W-1:0]         evcnt_q, evcnt_d;
  logic [31:0]                   prdata_q, prdata_d;

  logic                          access, rd_setup, wr_en, err;
  logic                          idx_hi, idx_ro;
  reg_idx_e                      idx;
  logic [3:0]                    clr, ev_inc, rise, fall;
  logic [FILTER_W-1:0]           filt_lim;
  logic                          unused_pwdata;

  // APB decode; any address above 8 (including upper bits) is out of range.
  assign idx      = reg_idx_e'(apb.paddr_i[3:0]);
  assign idx_hi   = (|apb.paddr_i[31:4]) | (apb.paddr_i[3:0] > 4'd8);
  assign idx_ro   = (apb.paddr_i[3:0] >= 4'd3) & (apb.paddr_i[3:0] <= 4'd7);
  assign access   = apb.psel_i & apb.penable_i;
  assign rd_setup = apb.psel_i & ~apb.penable_i & ~apb.pwrite_i;
  assign err      = access & (idx_hi | (apb.pwrite_i & idx_ro));
  assign wr_en    = access & apb.pwrite_i & ~err;

  assign apb.pslverr_o = err;
  assign apb.pready_o  = 1'b1;
  assign apb.prdata_o  = prdata_q;
  assign irq_trigger_o = trig_q;
  assign unused_pwdata = ^apb.pwdata_i[31:8];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    filt_n_d = filt_n_q;
    clr      = '0;
    if (wr_en) begin
      case (idx)
        REG_CTRL:    en_d     = apb.pwdata_i[0];
        REG_MODE:    mode_d   = apb.pwdata_i[7:0];
        REG_FILTER:  filt_n_d = apb.pwdata_i[FILTER_W-1:0];
        REG_CNT_CLR: clr      = apb.pwdata_i[3:0];
        default: ;
      endcase
    end
  end

  // N of 0 and 1 both mean a single matching cycle is enough to follow s2.
  assign filt_lim = (filt_n_q == '0) ? '0 : filt_n_q - FILTER_W'(1);

  always_comb begin
    s1_d    = irq_i;
    s2_d    = s1_q;
    f_dly_d = f_q;
    f_d     = f_q;
    fcnt_d  = '0;
    for (int k = 0; k < 4; k++) begin
      if (s2_q[k] != f_q[k]) begin
        if (fcnt_q[k] >= filt_lim) f_d[k] = s2_q[k];
        else fcnt_d[k] = fcnt_q[k] + FILTER_W'(1);
      end
    end
  end

  assign rise = f_q & ~f_dly_q;
  assign fall = ~f_q & f_dly_q;

  // Level mode counts assertions, edge modes count the pulses they emit.
  always_comb begin
    trig_d = '0;
    ev_inc = '0;
    for (int k = 0; k < 4; k++) begin
      case (trig_mode_e'(mode_q[2*k +: 2]))
        MODE_LEVEL: begin trig_d[k] = f_q[k];  ev_inc[k] = rise[k]; end
        MODE_RISE:  begin trig_d[k] = rise[k]; ev_inc[k] = rise[k]; end
        MODE_FALL:  begin trig_d[k] = fall[k]; ev_inc[k] = fall[k]; end
        default:    begin
          trig_d[k] = rise[k] | fall[k];
          ev_inc[k] = rise[k] | fall[k];
        end
      endcase
    end
    if (!en_q) begin
      trig_d = '0;
      ev_inc = '0;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      evcnt_d[k] = evcnt_q[k];
      if (clr[k]) evcnt_d[k] = '0;
      else if (ev_inc[k] && (evcnt_q[k] != {CNT_W{1'b1}})) evcnt_d[k] = evcnt_q[k] + CNT_W'(1);
    end
  end

  always_comb begin
    prdata_d = prdata_q;
    if (rd_setup) begin
      prdata_d = '0;
      if (!idx_hi) begin
        case (idx)
          REG_CTRL:   prdata_d = {31'b0, en_q};
          REG_MODE:   prdata_d = {24'b0, mode_q};
          REG_FILTER: prdata_d = 32'(filt_n_q);
          REG_RAW:    prdata_d = {28'b0, s2_q};
          REG_CNT0, REG_CNT1, REG_CNT2, REG_CNT3:
                      prdata_d = 32'(evcnt_q[apb.paddr_i[1:0]]);
          default: ;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the per-line
  // counters are plain flops, so they reset with everything else.
  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q     <= 1'b1;
      mode_q   <= '0;
      filt_n_q <= FILTER_W'(2);
      s1_q     <= '0;
      s2_q     <= '0;
      f_q      <= '0;
      f_dly_q  <= '0;
      fcnt_q   <= '0;
      trig_q   <= '0;
      evcnt_q  <= '0;
      prdata_q <= '0;
    end else begin
      en_q     <= en_d;
      mode_q   <= mode_d;
      filt_n_q <= filt_n_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      f_q      <= f_d;
      f_dly_q  <= f_dly_d;
      fcnt_q   <= fcnt_d;
      trig_q   <= trig_d;
      evcnt_q  <= evcnt_d;
      prdata_q <= prdata_d;
    end
  end

endmodule

// File: tb/tb_irq_input_conditioner.sv
// Self-checking bench: directed scenarios plus randomized traffic, all checked
// against a history-window reference model of the conditioner.
module tb_irq_input_conditioner;

  logic       pclk_i;
  logic       rst_i;
  logic [3:0] irq_i;
  logic [3:0] irq_trigger_o;

  irq_input_conditioner_if apb ();

  irq_input_conditioner #(.FILTER_W(4), .CNT_W(8)) dut (
    .pclk_i        (pclk_i),
    .rst_i         (rst_i),
    .apb           (apb),
    .irq_i         (irq_i),
    .irq_trigger_o (irq_trigger_o)
  );

  initial begin
    pclk_i = 1'b0;
    forever #5 pclk_i = ~pclk_i;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: histories indexed by edge number (mod 64).
  logic [3:0]  irq_at [64];
  logic [3:0]  s2_h   [64];
  logic [3:0]  f_h    [64];
  int          t;
  logic        m_en;
  logic [7:0]  m_mode;
  logic [3:0]  m_n;
  int          m_cnt [4];
  logic [3:0]  m_trig;
  logic        pend_vld;
  int          pend_idx;
  logic [31:0] pend_data;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      irq_at[i] = '0; s2_h[i] = '0; f_h[i] = '0;
    end
    t = 100;
    m_en = 1'b1; m_mode = '0; m_n = 4'd2; m_trig = '0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    pend_vld = 1'b0;
  endtask

  // One rising edge: s2 is irq two edges old; f flips once the last
  // max(N,1) synchronized samples all disagree with it.
  task automatic model_step();
    int m;
    logic [3:0] fp, fpp, fn;
    logic diff_all, tb, ev;
    t++;
    irq_at[t & 63] = irq_i;
    s2_h[t & 63]   = irq_at[(t - 1) & 63];
    m   = (m_n == 0) ? 1 : int'(m_n);
    fp  = f_h[(t - 1) & 63];
    fpp = f_h[(t - 2) & 63];
    for (int k = 0; k < 4; k++) begin
      diff_all = 1'b1;
      for (int j = 1; j <= m; j++)
        if (s2_h[(t - j) & 63][k] == fp[k]) diff_all = 1'b0;
      fn[k] = diff_all ? ~fp[k] : fp[k];
    end
    f_h[t & 63] = fn;
    for (int k = 0; k < 4; k++) begin
      case (m_mode[2*k +: 2])
        2'b00:   begin tb = fp[k];             ev = fp[k] & ~fpp[k]; end
        2'b01:   begin tb = fp[k] & ~fpp[k];   ev = tb; end
        2'b10:   begin tb = ~fp[k] & fpp[k];   ev = tb; end
        default: begin tb = fp[k] ^ fpp[k];    ev = tb; end
      endcase
      m_trig[k] = m_en & tb;
      if (m_en && ev && m_cnt[k] < 255) m_cnt[k]++;
    end
    if (pend_vld) begin
      case (pend_idx)
        0: m_en   = pend_data[0];
        1: m_mode = pend_data[7:0];
        2: m_n    = pend_data[3:0];
        8: for (int k = 0; k < 4; k++) if (pend_data[k]) m_cnt[k] = 0;
        default: ;
      endcase
      pend_vld = 1'b0;
    end
  endtask

  function automatic logic [31:0] model_read(input int idx);
    case (idx)
      0:       return {31'b0, m_en};
      1:       return {24'b0, m_mode};
      2:       return {28'b0, m_n};
      3:       return {28'b0, s2_h[t & 63]};
      4, 5, 6, 7: return 32'(m_cnt[idx - 4]);
      default: return 32'h0;
    endcase
  endfunction

  task automatic cycle();
    @(posedge pclk_i);
    model_step();
    @(negedge pclk_i);
    check("trig", {28'b0, irq_trigger_o}, {28'b0, m_trig});
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic apb_write(input int idx, input logic [31:0] d);
    logic e;
    e = (idx > 8) || (idx >= 3 && idx <= 7);
    apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = 1'b1;
    apb.paddr_i = 32'(idx); apb.pwdata_i = d;
    cycle();
    apb.penable_i = 1'b1;
    #1;
    check("wr_err", {31'b0, apb.pslverr_o}, {31'b0, e});
    pend_vld = !e; pend_idx = idx; pend_data = d;
    cycle();
    apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
  endtask

  task automatic apb_read(input string tag, input int idx, output logic [31:0] v);
    logic [31:0] exp;
    exp = model_read(idx);
    apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
    apb.paddr_i = 32'(idx);
    cycle();
    apb.penable_i = 1'b1;
    #1;
    check("rd_err", {31'b0, apb.pslverr_o}, {31'b0, idx > 8});
    check(tag, apb.prdata_o, exp);
    v = apb.prdata_o;
    cycle();
    apb.psel_i = 1'b0; apb.penable_i = 1'b0;
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    #1;
    check("rst_trig", {28'b0, irq_trigger_o}, 32'h0);
    model_reset();
    @(negedge pclk_i);
    @(negedge pclk_i);
    rst_i = 1'b0;
  endtask

  task automatic reset_reads();
    logic [31:0] v;
    apb_read("rst_ctrl", 0, v);   check("rst_ctrl_val", v, 32'h1);
    apb_read("rst_mode", 1, v);   check("rst_mode_val", v, 32'h0);
    apb_read("rst_filter", 2, v); check("rst_filter_val", v, 32'h2);
    for (int k = 4; k < 8; k++) begin
      apb_read("rst_cnt", k, v);  check("rst_cnt_val", v, 32'h0);
    end
  endtask

  int hold [4];

  task automatic rand_irq_cycle(input int max_hold);
    for (int k = 0; k < 4; k++) begin
      if (hold[k] == 0) begin
        irq_i[k] = ~irq_i[k];
        hold[k]  = $urandom_range(1, max_hold);
      end else hold[k]--;
    end
    cycle();
  endtask

  initial begin
    logic [31:0] v;
    int w;
    irq_i = '0;
    apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
    apb.paddr_i = '0; apb.pwdata_i = '0;
    for (int k = 0; k < 4; k++) hold[k] = 0;

    reset_dut();
    check("idle_err", {31'b0, apb.pslverr_o}, 32'h0);
    check("pready", {31'b0, apb.pready_o}, 32'h1);
    reset_reads();

    // Level mode, N = 2: rise after edge 5, fall 5 edges after release.
    irq_i[0] = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      cycle();
      if (e == 4) check("lvl_rise_pre", {31'b0, irq_trigger_o[0]}, 32'h0);
      if (e == 5) check("lvl_rise", {31'b0, irq_trigger_o[0]}, 32'h1);
    end
    apb_read("lvl_cnt0", 4, v); check("lvl_cnt0_val", v, 32'h1);
    irq_i[0] = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      cycle();
      if (e == 4) check("lvl_fall_pre", {31'b0, irq_trigger_o[0]}, 32'h1);
      if (e == 5) check("lvl_fall", {31'b0, irq_trigger_o[0]}, 32'h0);
    end

    // Glitch filter at N = 4.
    apb_write(2, 32'h4);
    irq_i[1] = 1'b1; cycles(3); irq_i[1] = 1'b0; cycles(20);
    apb_read("glitch_cnt1", 5, v); check("glitch_drop", v, 32'h0);
    irq_i[1] = 1'b1; cycles(4); irq_i[1] = 1'b0; cycles(20);
    apb_read("pass_cnt1", 5, v); check("glitch_pass", v, 32'h1);

    // Edge modes on all four lines.
    apb_write(2, 32'h2);
    apb_write(1, 32'hE4);
    apb_write(8, 32'hF);
    irq_i = 4'hF; cycles(8); irq_i = 4'h0; cycles(15);
    apb_read("edge_cnt0", 4, v); check("edge_cnt0_val", v, 32'h1);
    apb_read("edge_cnt1", 5, v); check("edge_cnt1_val", v, 32'h1);
    apb_read("edge_cnt2", 6, v); check("edge_cnt2_val", v, 32'h1);
    apb_read("edge_cnt3", 7, v); check("edge_cnt3_val", v, 32'h2);

    // Saturation on line 2 (rising mode, no filtering), then clear vs. edge.
    apb_write(1, 32'h10);
    apb_write(2, 32'h1);
    for (int i = 0; i < 300; i++) begin
      irq_i[2] = 1'b1; cycles(2); irq_i[2] = 1'b0; cycles(2);
    end
    cycles(6);
    apb_read("sat_cnt2", 6, v); check("sat_val", v, 32'hFF);
    irq_i[2] = 1'b1; cycles(2);
    apb_write(8, 32'h4);
    cycles(4);
    apb_read("clr_cnt2", 6, v); check("clr_wins", v, 32'h0);
    irq_i[2] = 1'b0; cycles(6);

    // APB errors and enable gating.
    apb_write(5, 32'hFF);
    apb_write(9, 32'h0);
    apb_write(3, 32'hF);
    apb_read("err_ctrl", 0, v);
    apb_read("err_mode", 1, v);
    apb_read("err_filter", 2, v);
    apb_read("err_cnt1", 5, v);
    apb_read("clr_read", 8, v); check("clr_read_zero", v, 32'h0);
    apb_read("oob_read", 12, v);
    apb_write(1, 32'hE4);
    apb_write(0, 32'h0);
    for (int i = 0; i < 100; i++) rand_irq_cycle(6);
    for (int k = 4; k < 8; k++) apb_read("dis_cnt", k, v);
    apb_write(0, 32'h1);

    // Randomized traffic with random configuration changes.
    for (int i = 0; i < 2500; i++) begin
      int r, idx;
      r = $urandom_range(0, 59);
      if (r == 0) begin
        idx = $urandom_range(0, 10);
        case (idx)
          0: apb_write(0, {31'b0, $urandom_range(0, 3) != 0});
          1: apb_write(1, $urandom);
          2: apb_write(2, 32'($urandom_range(0, 6)));
          8: apb_write(8, 32'($urandom_range(0, 15)));
          default: apb_write(idx, $urandom);
        endcase
      end else if (r == 1) begin
        apb_read("rnd_rd", $urandom_range(0, 10), v);
      end else begin
        rand_irq_cycle(8);
      end
    end
    for (int k = 0; k < 9; k++) apb_read("final_rd", k, v);

    // Reset asserted while a level trigger is high.
    irq_i = '0;
    apb_write(0, 32'h1);
    apb_write(1, 32'h0);
    apb_write(2, 32'h2);
    cycles(10);
    irq_i[0] = 1'b1;
    w = 0;
    while (!irq_trigger_o[0] && w < 20) begin
      cycle();
      w++;
    end
    check("wait_trig", {31'b0, irq_trigger_o[0]}, 32'h1);
    @(posedge pclk_i);
    #2;
    reset_dut();
    irq_i = '0;
    reset_reads();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
